// File: rtl/mem_sweep_pkg.sv
// mem_sweep_pkg: shared types and default sizing for the sweep reader.
package mem_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } sweep_state_t;

    // Default address width and the matching count width (one extra bit so
    // that count can reach SIZE and start+count never wraps)
    localparam int unsigned DEF_IDX_SIZE = 4;
    localparam int unsigned CNT_W        = DEF_IDX_SIZE + 1;

endpackage

// File: rtl/mem_sweep_out_reg.sv
// mem_sweep_out_reg: single valid/ready output register stage.
// load_req asks for a new word; the stage accepts it only when empty or when
// the current word is being taken in the same cycle.
module mem_sweep_out_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_req,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             load,
    output logic             accept
);

    assign load   = load_req && (!valid || ready);
    assign accept = valid && ready;

    // Data/valid register: load wins, otherwise a handshake empties the stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_d1_sweep_reader.sv
// mem_d1_sweep_reader: sweeps a contiguous range of a 1-D memory and streams
// the words out on valid/ready, then pulses done (with err on a bad range).
// Optional feature: define MEM_SWEEP_CHECKSUM_EN to add the checksum output.
module mem_d1_sweep_reader
    import mem_sweep_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 16,
    parameter int unsigned IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic [IDX_SIZE-1:0] start_addr,
    input  logic [IDX_SIZE:0]   count,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic                mem_write_en,
    input  logic [WIDTH-1:0]    mem_read_data,
`ifdef MEM_SWEEP_CHECKSUM_EN
    output logic [WIDTH-1:0]    checksum,
`endif
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned SWEEP_CNT_W = IDX_SIZE + 1;

    sweep_state_t           state;
    logic [IDX_SIZE-1:0]    addr_q;
    logic [SWEEP_CNT_W-1:0] remaining;
    logic [SWEEP_CNT_W-1:0] end_addr;
    logic                   range_err;
    logic                   load_req;
    logic                   load;
    logic                   accept;

    assign mem_write_en = 1'b0;
    assign mem_addr0    = addr_q;

    // Range check at full count width so start+count cannot wrap
    assign end_addr  = {1'b0, start_addr} + count;
    assign range_err = end_addr > SWEEP_CNT_W'(SIZE);

    assign load_req = (state == READ);

    mem_sweep_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_req (load_req),
        .din      (mem_read_data),
        .ready    (out_ready),
        .dout     (out_data),
        .valid    (out_valid),
        .load     (load),
        .accept   (accept)
    );

    // Sweep FSM with registered busy/done/err, address and remaining counters.
    // The address is not advanced on the final load so mem_addr0 keeps
    // showing the last address read once the sweep leaves READ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            addr_q    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        busy <= 1'b1;
                        if (count == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (range_err) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            addr_q    <= start_addr;
                            remaining <= count;
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    if (load) begin
                        remaining <= remaining - SWEEP_CNT_W'(1);
                        if (remaining == SWEEP_CNT_W'(1)) begin
                            state <= DRAIN;
                        end else begin
                            addr_q <= addr_q + IDX_SIZE'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_SWEEP_CHECKSUM_EN
    // Running sum of accepted stream words, cleared by any go taken in IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (state == IDLE && go) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_d1_sweep_reader.sv
// tb_mem_d1_sweep_reader: directed scoreboard bench for mem_d1_sweep_reader.
module tb_mem_d1_sweep_reader;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned SIZE     = 16;
    localparam int unsigned IDX_SIZE = 4;

    logic                clk;
    logic                reset_n;
    logic                go;
    logic [IDX_SIZE-1:0] start_addr;
    logic [IDX_SIZE:0]   count;
    logic                busy;
    logic                done;
    logic                err;
    logic [IDX_SIZE-1:0] mem_addr0;
    logic                mem_write_en;
    logic [WIDTH-1:0]    mem_read_data;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
`ifdef MEM_SWEEP_CHECKSUM_EN
    logic [WIDTH-1:0]    checksum;
`endif

    logic [WIDTH-1:0] mem_arr [SIZE];
    assign mem_read_data = mem_arr[mem_addr0];

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] exp_sum;
    logic             held_v = 1'b0;
    logic [WIDTH-1:0] held_d;

    mem_d1_sweep_reader #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .IDX_SIZE (IDX_SIZE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .go            (go),
        .start_addr    (start_addr),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mem_addr0     (mem_addr0),
        .mem_write_en  (mem_write_en),
        .mem_read_data (mem_read_data),
`ifdef MEM_SWEEP_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: checks stall stability and pops the scoreboard on each handshake
    always @(negedge clk) begin
        if (!reset_n) begin
            held_v <= 1'b0;
        end else if (out_valid) begin
            if (held_v) check("stall_stable", out_data, held_d);
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", out_data, 32'hDEAD_BEEF ^ out_data);
                end else begin
                    check("stream_word", out_data, sb_q.pop_front());
                end
                acc_cnt++;
                held_v <= 1'b0;
            end else begin
                held_v <= 1'b1;
                held_d <= out_data;
            end
        end else begin
            held_v <= 1'b0;
        end
    end

    // One sweep: mode 0 = ready held high, mode 1 = ready pattern 1,0,0,1
    task automatic sweep(input int st, input int cnt, input int mode, input bit exp_err,
                         input int exp_done, input bit stray_go);
        int cyc;
        int done_cyc;
        int dones;
        exp_sum = '0;
        if (!exp_err) begin
            for (int i = 0; i < cnt; i++) begin
                sb_q.push_back(mem_arr[st + i]);
                exp_sum = exp_sum + mem_arr[st + i];
            end
        end
        @(posedge clk); #1;
        go = 1'b1; start_addr = IDX_SIZE'(st); count = (IDX_SIZE+1)'(cnt);
        @(posedge clk); #1;
        go = 1'b0;
        cyc = 1; done_cyc = -1; dones = 0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        if (cnt > 0 && !exp_err) check("first_addr", {28'd0, mem_addr0}, st);
        while (cyc < 80 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stray_go && cyc == 2) begin
                go = 1'b1; start_addr = '0; count = 5'd1;
            end else begin
                go = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                check("err_at_done", {31'd0, err}, {31'd0, exp_err});
`ifdef MEM_SWEEP_CHECKSUM_EN
                check("checksum", checksum, exp_sum);
`endif
            end
            @(posedge clk); #1;
            cyc++;
        end
        go = 1'b0;
        out_ready = 1'b1;
        if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        else check("done_seen", {31'd0, done_cyc > 0}, 32'd1);
        check("done_count", dones, 1);
        check("sb_empty", sb_q.size(), 0);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("valid_idle", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_addr",  {28'd0, mem_addr0}, 32'd0);
        check("rst_wen",   {31'd0, mem_write_en}, 32'd0);
`ifdef MEM_SWEEP_CHECKSUM_EN
        check("rst_checksum", checksum, 32'd0);
`endif
    endtask

    initial begin
        int waited;
        for (int i = 0; i < SIZE; i++) mem_arr[i] = 32'(i * 3);
        reset_n = 1'b0; go = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
        #12;
        check_reset_vals();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Basic sweep: 6, 9, 12, 15 with done in cycle 6
        sweep(2, 4, 0, 1'b0, 6, 1'b0);
        // Backpressure with ready 1,0,0,1
        sweep(2, 4, 1, 1'b0, -1, 1'b0);
        sweep(0, 16, 1, 1'b0, -1, 1'b0);
        // Boundary ranges
        sweep(12, 4, 0, 1'b0, 6, 1'b0);
        sweep(13, 4, 0, 1'b1, 1, 1'b0);
        // Zero count
        sweep(5, 0, 0, 1'b0, 1, 1'b0);
        // Ignored go during READ
        sweep(1, 5, 0, 1'b0, 7, 1'b1);

        // Reset mid-sweep after two words
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) sb_q.push_back(mem_arr[i]);
        @(posedge clk); #1;
        go = 1'b1; start_addr = '0; count = 5'd8;
        @(posedge clk); #1;
        go = 1'b0;
        waited = 0;
        while (acc_cnt < 2 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("midsweep_reached", {31'd0, acc_cnt >= 2}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        sweep(0, 1, 0, 1'b0, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_d1_sweep_reader.md
# mem_d1_sweep_reader

Initiator-side companion to the single-port 1-D memory primitive (`addr0` / `read_data` / `write_data` / `write_en` / `done`). On a `go` pulse it sweeps a contiguous address range, samples the memory's combinational read port, and streams each word out on a valid/ready interface. It then reports completion with a one-cycle `done` pulse, using the same go/done control style as other codebase primitives. It sits between a memory instance and any streaming consumer, such as a DMA, a serializer or a checker.

## Interface
- `WIDTH`, default 32: memory word width; width of `out_data`.
- `SIZE`, default 16: number of words in the attached memory.
- `IDX_SIZE`, default 4: address width; must satisfy 2^IDX_SIZE >= SIZE.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1 bit: the single clock; all state changes on the rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `go`, input, 1 bit: start request; sampled only in IDLE.
- `start_addr`, input, IDX_SIZE bits: first address; sampled with `go`.
- `count`, input, IDX_SIZE+1 bits: number of words to read (0..SIZE); sampled with `go`.
- `busy`, output, 1 bit: high in every state except IDLE.
- `done`, output, 1 bit: one-cycle completion pulse.
- `err`, output, 1 bit: one-cycle pulse for a rejected range; coincides with `done`.
- `mem_addr0`, output, IDX_SIZE bits: drives the memory `addr0`.
- `mem_write_en`, output, 1 bit: constant 0; this block never writes.
- `mem_read_data`, input, WIDTH bits: the memory's combinational `read_data`.
- `out_data`, output, WIDTH bits: current stream word; registered.
- `out_valid`, output, 1 bit: `out_data` is valid.
- `out_ready`, input, 1 bit: consumer accepts the word this cycle.

## Operation
- States, defined in the package enum: IDLE, READ, DRAIN, FIN.
- IDLE
  - `go`=1 with count=0: go to FIN; no reads.
  - `go`=1 with start_addr+count > SIZE (computed at IDX_SIZE+1 bits, no wrap): go to FIN with `err` flagged; no reads.
  - Any other `go`=1: latch `start_addr` into the address counter, latch `count` into the remaining-count register, go to READ.
- READ
  - `mem_addr0` = address counter.
  - The output register loads when `!out_valid || out_ready`. On a load, `out_data` ← `mem_read_data`, `out_valid` ← 1, the address increments and remaining decrements.
  - The load that takes remaining to 0 moves the FSM to DRAIN.
- DRAIN
  - Holds until the final word is accepted (`out_valid && out_ready`), then goes to FIN.
  - `out_valid` drops in the cycle after acceptance.
- FIN
  - `done`=1, plus `err` if flagged, for exactly one cycle.
  - Returns to IDLE; the `err` flag clears.
- When the output register is not loading, a handshake with `out_ready`=1 clears `out_valid`.
- Backpressure: `out_data` and `out_valid` stay stable while `out_valid && !out_ready`.
- `mem_addr0` equals the last address used when not in READ; it holds its reset value of 0 until the first `go`.
- `go` outside IDLE is ignored; there is no queuing.
- Reset, including mid-sweep, returns to IDLE and discards any in-flight word. Reset values:
  - `busy`=0, `done`=0, `err`=0, `out_valid`=0
  - `out_data`=0, `mem_addr0`=0, `mem_write_en`=0

## Timing
- Cycle 0: `go` is sampled in IDLE. Cycle 1: READ, with `mem_addr0`=start_addr. Cycle 2: first `out_valid`.
- Latency from `go` to first `out_valid` is 2 cycles.
- With `out_ready` held high, throughput is one word per cycle.
- For count=N with no stalls, `done` is high in cycle N+2.
- count=0 or a range error: `done` is high in cycle 1, and `out_valid` never rises.
- `busy` rises in the cycle after `go` and falls in the cycle after `done`.

## Configuration
- Macro: `MEM_SWEEP_CHECKSUM_EN`.
- When defined:
  - Adds an output port `checksum`, WIDTH bits.
  - It holds the sum, modulo 2^WIDTH, of every word accepted on the stream.
  - It clears to 0 on an accepted `go`, is final when `done` is high, and holds until the next `go`.
  - Reset value is 0.
- When undefined: no `checksum` port and no adder logic.

## Structure
- Package `mem_sweep_pkg`:
  - State enum `sweep_state_t` (IDLE, READ, DRAIN, FIN).
  - Localparam `CNT_W` = IDX_SIZE+1.
- One sub-module, `mem_sweep_out_reg`: a WIDTH-bit valid/ready output register stage with load and accept logic.
- The top level holds the FSM, the counters, the range check and the optional checksum.

## Test plan
- **Basic sweep.** Memory[i]=i*3, start=2, count=4, `out_ready`=1 → outputs 6, 9, 12, 15 on consecutive cycles; `done` in cycle 6; checksum=42 when enabled.
- **Backpressure.** Same setup with `out_ready` toggling 1,0,0,1,… → no dropped or duplicated words; `out_data` stable while stalled; order preserved.
- **Boundary range.** start=12, count=4, SIZE=16 → reads addresses 12..15 with no error. start=13, count=4 → `err` and `done` together in cycle 1, zero stream words.
- **Zero count.** count=0 → `done` in cycle 1; `out_valid` stays 0; checksum=0.
- **Reset mid-sweep.** Assert `reset_n`=0 after 2 of 8 words → all outputs take their reset values immediately. A following `go` with start=0, count=1 runs normally.
- **Ignored go.** Pulse `go` during READ with different arguments → the original sweep completes unchanged, with exactly one `done`.
